// File: rtl/efx_syncfifo_asym_if.sv
// Request/data/status bundle for efx_syncfifo_asym.
// The slave modport is the FIFO side; the master modport is the user side.
interface efx_syncfifo_asym_if #(
  parameter int DEPTH       = 512,
  parameter int WDATA_WIDTH = 8,
  parameter int RATIO       = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                         wr_en_i;
  logic [WDATA_WIDTH-1:0]       wdata;
  logic                         rd_en_i;
  logic [WDATA_WIDTH*RATIO-1:0] rdata;
  logic                         full_o;
  logic                         almost_full_o;
  logic                         prog_full_o;
  logic                         empty_o;
  logic                         almost_empty_o;
  logic                         prog_empty_o;
  logic                         wr_ack_o;
  logic                         overflow_o;
  logic                         rd_valid_o;
  logic                         underflow_o;
  logic [CW-1:0]                datacount_o;

  modport master (
    output wr_en_i, wdata, rd_en_i,
    input  rdata, full_o, almost_full_o, prog_full_o,
           empty_o, almost_empty_o, prog_empty_o,
           wr_ack_o, overflow_o, rd_valid_o, underflow_o, datacount_o
  );

  modport slave (
    input  wr_en_i, wdata, rd_en_i,
    output rdata, full_o, almost_full_o, prog_full_o,
           empty_o, almost_empty_o, prog_empty_o,
           wr_ack_o, overflow_o, rd_valid_o, underflow_o, datacount_o
  );
endinterface

// File: rtl/efx_syncfifo_asym.sv
// Single-clock FIFO: narrow writes, RATIO-wide reads, STANDARD or FWFT read port.
// Define EFX_FIFO_HANDSHAKE_EN to generate wr_ack_o/overflow_o/underflow_o.
module efx_syncfifo_asym #(
  parameter int    DEPTH             = 512,
  parameter int    WDATA_WIDTH       = 8,
  parameter int    RATIO             = 4,
  parameter string MODE              = "STANDARD",
  parameter int    PROG_FULL_ASSERT  = DEPTH - 16,
  parameter int    PROG_EMPTY_ASSERT = 16
) (
  input  logic               clk_i,
  input  logic               a_rst_i,
  efx_syncfifo_asym_if.slave bus
);
  localparam int  RDATA_WIDTH = WDATA_WIDTH * RATIO;
  localparam int  PW          = $clog2(DEPTH);
  localparam int  LW          = $clog2(RATIO);
  localparam int  RW          = PW - LW;
  localparam int  CW          = PW + 1;
  localparam bit  FWFT        = (MODE == "FWFT");

  localparam logic [CW-1:0] FULL_TH  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PFULL_TH = CW'(PROG_FULL_ASSERT);
  localparam logic [CW-1:0] PEMPT_TH = CW'(PROG_EMPTY_ASSERT);
  localparam logic [CW-1:0] RATIO_C  = CW'(RATIO);
  localparam logic [CW-1:0] RATIO2_C = CW'(2 * RATIO);

  logic [WDATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rd_valid_q, rd_valid_d;

  logic                   full_s;
  logic                   empty_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic [PW-1:0]          rd_base_s;
  logic [RDATA_WIDTH-1:0] head_word_s;

  // Flags are decoded straight from the registered occupancy.
  assign full_s   = (count_q == FULL_TH);
  assign empty_s  = (count_q < RATIO_C);

  assign bus.full_o         = full_s;
  assign bus.almost_full_o  = (count_q >= AFULL_TH);
  assign bus.prog_full_o    = (count_q >= PFULL_TH);
  assign bus.empty_o        = empty_s;
  assign bus.almost_empty_o = (count_q < RATIO2_C);
  assign bus.prog_empty_o   = (count_q <= PEMPT_TH);
  assign bus.datacount_o    = count_q;

  // Requests arriving during reset are dropped.
  assign wr_acc_s = bus.wr_en_i & ~full_s  & ~a_rst_i;
  assign rd_acc_s = bus.rd_en_i & ~empty_s & ~a_rst_i;

  assign rd_base_s = PW'(rd_ptr_q) << LW;

  // Gather RATIO consecutive write words; lowest address lands in the LSBs.
  always_comb begin
    head_word_s = '0;
    for (int k = 0; k < RATIO; k++) begin
      head_word_s[k*WDATA_WIDTH +: WDATA_WIDTH] = mem_q[rd_base_s + PW'(k)];
    end
  end

  // Next-state for pointers, occupancy and the registered read port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    count_d    = count_q + (wr_acc_s ? CW'(1) : CW'(0)) - (rd_acc_s ? RATIO_C : CW'(0));
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d   = rd_ptr_q + RW'(1);
      rdata_d    = head_word_s;
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rdata_d    = rdata_q;
      rd_valid_d = 1'b0;
    end
  end

  // State registers; reset empties the FIFO by clearing pointers and count.
  always_ff @(posedge clk_i) begin
    if (a_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array, left unreset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= bus.wdata;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown combinationally; forced to zero while empty.
      assign bus.rdata      = empty_s ? '0 : head_word_s;
      assign bus.rd_valid_o = ~empty_s;
    end else begin : g_std
      assign bus.rdata      = rdata_q;
      assign bus.rd_valid_o = rd_valid_q;
    end
  endgenerate

`ifdef EFX_FIFO_HANDSHAKE_EN
  logic wr_ack_q;
  logic overflow_q;
  logic underflow_q;

  // One-cycle-late handshake pulses for accepted and rejected requests.
  always_ff @(posedge clk_i) begin
    if (a_rst_i) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc_s;
      overflow_q  <= bus.wr_en_i & full_s;
      underflow_q <= bus.rd_en_i & empty_s;
    end
  end

  assign bus.wr_ack_o    = wr_ack_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
`else
  assign bus.wr_ack_o    = 1'b0;
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_efx_syncfifo_asym.sv
// Directed bench for efx_syncfifo_asym: three 16-deep instances
// (RATIO 4 STANDARD, RATIO 1 STANDARD, RATIO 2 FWFT) sharing clock and reset.
module tb_efx_syncfifo_asym;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

`ifdef EFX_FIFO_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  always #5 clk = ~clk;

  efx_syncfifo_asym_if #(.DEPTH(16), .WDATA_WIDTH(8), .RATIO(4)) if_a ();
  efx_syncfifo_asym_if #(.DEPTH(16), .WDATA_WIDTH(8), .RATIO(1)) if_b ();
  efx_syncfifo_asym_if #(.DEPTH(16), .WDATA_WIDTH(8), .RATIO(2)) if_c ();

  efx_syncfifo_asym #(.DEPTH(16), .WDATA_WIDTH(8), .RATIO(4), .MODE("STANDARD"),
                      .PROG_FULL_ASSERT(12), .PROG_EMPTY_ASSERT(4))
    u_a (.clk_i(clk), .a_rst_i(rst), .bus(if_a.slave));
  efx_syncfifo_asym #(.DEPTH(16), .WDATA_WIDTH(8), .RATIO(1), .MODE("STANDARD"),
                      .PROG_FULL_ASSERT(14), .PROG_EMPTY_ASSERT(2))
    u_b (.clk_i(clk), .a_rst_i(rst), .bus(if_b.slave));
  efx_syncfifo_asym #(.DEPTH(16), .WDATA_WIDTH(8), .RATIO(2), .MODE("FWFT"),
                      .PROG_FULL_ASSERT(12), .PROG_EMPTY_ASSERT(4))
    u_c (.clk_i(clk), .a_rst_i(rst), .bus(if_c.slave));

  // {full, almost_full, prog_full, empty, almost_empty, prog_empty}
  logic [5:0] fl_a, fl_b, fl_c;
  // {wr_ack, overflow, underflow}
  logic [2:0] hs_a, hs_b, hs_c;
  assign fl_a = {if_a.full_o, if_a.almost_full_o, if_a.prog_full_o,
                 if_a.empty_o, if_a.almost_empty_o, if_a.prog_empty_o};
  assign fl_b = {if_b.full_o, if_b.almost_full_o, if_b.prog_full_o,
                 if_b.empty_o, if_b.almost_empty_o, if_b.prog_empty_o};
  assign fl_c = {if_c.full_o, if_c.almost_full_o, if_c.prog_full_o,
                 if_c.empty_o, if_c.almost_empty_o, if_c.prog_empty_o};
  assign hs_a = {if_a.wr_ack_o, if_a.overflow_o, if_a.underflow_o};
  assign hs_b = {if_b.wr_ack_o, if_b.overflow_o, if_b.underflow_o};
  assign hs_c = {if_c.wr_ack_o, if_c.overflow_o, if_c.underflow_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.wr_en_i = 1'b0; if_a.rd_en_i = 1'b0; if_a.wdata = 8'h00;
    if_b.wr_en_i = 1'b0; if_b.rd_en_i = 1'b0; if_b.wdata = 8'h00;
    if_c.wr_en_i = 1'b0; if_c.rd_en_i = 1'b0; if_c.wdata = 8'h00;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // requests held high during reset must be ignored
    rst = 1'b1;
    if_a.wr_en_i = 1'b1; if_a.rd_en_i = 1'b1; if_a.wdata = 8'h5A;
    if_b.wr_en_i = 1'b1; if_b.rd_en_i = 1'b1; if_b.wdata = 8'h5A;
    if_c.wr_en_i = 1'b1; if_c.rd_en_i = 1'b1; if_c.wdata = 8'h5A;
    tick();
    tick();
    total_cnt++;
    if ({fl_a, if_a.datacount_o, if_a.rdata, if_a.rd_valid_o, hs_a} !== {6'b000111, 5'd0, 32'h0, 1'b0, 3'b000})
      $display("FAIL reset_during_a got=%h exp=%h", {fl_a, if_a.datacount_o, if_a.rdata, if_a.rd_valid_o, hs_a},
               {6'b000111, 5'd0, 32'h0, 1'b0, 3'b000});
    else pass_cnt++;
    idle_all();
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({fl_a, if_a.datacount_o, if_a.rdata, if_a.rd_valid_o, hs_a} !== {6'b000111, 5'd0, 32'h0, 1'b0, 3'b000})
      $display("FAIL reset_after_a got=%h exp=%h", {fl_a, if_a.datacount_o, if_a.rdata, if_a.rd_valid_o, hs_a},
               {6'b000111, 5'd0, 32'h0, 1'b0, 3'b000});
    else pass_cnt++;
    total_cnt++;
    if ({fl_b, if_b.datacount_o, if_b.rdata, if_b.rd_valid_o, hs_b} !== {6'b000111, 5'd0, 8'h0, 1'b0, 3'b000})
      $display("FAIL reset_after_b got=%h exp=%h", {fl_b, if_b.datacount_o, if_b.rdata, if_b.rd_valid_o, hs_b},
               {6'b000111, 5'd0, 8'h0, 1'b0, 3'b000});
    else pass_cnt++;
    total_cnt++;
    if ({fl_c, if_c.datacount_o, if_c.rdata, if_c.rd_valid_o, hs_c} !== {6'b000111, 5'd0, 16'h0, 1'b0, 3'b000})
      $display("FAIL reset_after_c got=%h exp=%h", {fl_c, if_c.datacount_o, if_c.rdata, if_c.rd_valid_o, hs_c},
               {6'b000111, 5'd0, 16'h0, 1'b0, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_pack_r4();
    for (int i = 0; i < 4; i++) begin
      if_a.wdata   = 8'(17 * (i + 1));
      if_a.wr_en_i = 1'b1;
      tick();
      total_cnt++;
      if ({if_a.datacount_o, if_a.empty_o, if_a.wr_ack_o} !== {5'(i + 1), (i < 3), HS})
        $display("FAIL pack_write%0d got=%b exp=%b", i, {if_a.datacount_o, if_a.empty_o, if_a.wr_ack_o},
                 {5'(i + 1), (i < 3), HS});
      else pass_cnt++;
    end
    if_a.wr_en_i = 1'b0;
    total_cnt++;
    if (fl_a !== 6'b000011)
      $display("FAIL pack_flags4 got=%b exp=%b", fl_a, 6'b000011);
    else pass_cnt++;
    if_a.rd_en_i = 1'b1;
    tick();
    if_a.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_a.rdata, if_a.rd_valid_o, if_a.empty_o, if_a.datacount_o} !== {32'h44332211, 1'b1, 1'b1, 5'd0})
      $display("FAIL pack_read got=%h exp=%h", {if_a.rdata, if_a.rd_valid_o, if_a.empty_o, if_a.datacount_o},
               {32'h44332211, 1'b1, 1'b1, 5'd0});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if_a.rdata, if_a.rd_valid_o} !== {32'h44332211, 1'b0})
      $display("FAIL pack_hold got=%h exp=%h", {if_a.rdata, if_a.rd_valid_o}, {32'h44332211, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      if_a.wdata   = 8'(i);
      if_a.wr_en_i = 1'b1;
      tick();
    end
    total_cnt++;
    if ({if_a.datacount_o, fl_a} !== {5'd10, 6'b000000})
      $display("FAIL mid_fill got=%b exp=%b", {if_a.datacount_o, fl_a}, {5'd10, 6'b000000});
    else pass_cnt++;
    rst = 1'b1;
    if_a.rd_en_i = 1'b1;
    tick();
    rst = 1'b0;
    if_a.wr_en_i = 1'b0;
    if_a.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_a.datacount_o, fl_a, if_a.rdata, if_a.rd_valid_o, hs_a} !== {5'd0, 6'b000111, 32'h0, 1'b0, 3'b000})
      $display("FAIL mid_reset got=%h exp=%h", {if_a.datacount_o, fl_a, if_a.rdata, if_a.rd_valid_o, hs_a},
               {5'd0, 6'b000111, 32'h0, 1'b0, 3'b000});
    else pass_cnt++;
    if_a.rd_en_i = 1'b1;
    tick();
    if_a.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_a.underflow_o, if_a.rd_valid_o, if_a.datacount_o} !== {HS, 1'b0, 5'd0})
      $display("FAIL mid_underflow got=%b exp=%b", {if_a.underflow_o, if_a.rd_valid_o, if_a.datacount_o},
               {HS, 1'b0, 5'd0});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (if_a.underflow_o !== 1'b0)
      $display("FAIL mid_underflow_pulse got=%b exp=%b", if_a.underflow_o, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_overflow_r1();
    logic [5:0] exp_fl;
    logic       chk;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if_b.wdata   = 8'(i + 1);
      if_b.wr_en_i = 1'b1;
      tick();
      total_cnt++;
      if (i < 16) begin
        if ({if_b.datacount_o, hs_b} !== {5'(i + 1), HS, 2'b00})
          $display("FAIL ovf_write%0d got=%b exp=%b", i, {if_b.datacount_o, hs_b}, {5'(i + 1), HS, 2'b00});
        else pass_cnt++;
      end else begin
        if ({if_b.datacount_o, hs_b} !== {5'd16, 1'b0, HS, 1'b0})
          $display("FAIL ovf_17th got=%b exp=%b", {if_b.datacount_o, hs_b}, {5'd16, 1'b0, HS, 1'b0});
        else pass_cnt++;
      end
      chk = 1'b1;
      case (i)
        1:       exp_fl = 6'b000001;
        2:       exp_fl = 6'b000000;
        13:      exp_fl = 6'b001000;
        14:      exp_fl = 6'b011000;
        15, 16:  exp_fl = 6'b111000;
        default: begin exp_fl = 6'b000000; chk = 1'b0; end
      endcase
      if (chk) begin
        total_cnt++;
        if (fl_b !== exp_fl)
          $display("FAIL ovf_flags_cnt%0d got=%b exp=%b", i + 1, fl_b, exp_fl);
        else pass_cnt++;
      end
    end
    if_b.wr_en_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if_b.rd_en_i = 1'b1;
      tick();
      total_cnt++;
      if ({if_b.rdata, if_b.rd_valid_o} !== {8'(i + 1), 1'b1})
        $display("FAIL ovf_read%0d got=%h exp=%h", i, {if_b.rdata, if_b.rd_valid_o}, {8'(i + 1), 1'b1});
      else pass_cnt++;
    end
    tick();
    if_b.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_b.rd_valid_o, if_b.underflow_o, if_b.rdata, if_b.datacount_o, if_b.empty_o} !==
        {1'b0, HS, 8'd16, 5'd0, 1'b1})
      $display("FAIL ovf_extra_read got=%h exp=%h",
               {if_b.rd_valid_o, if_b.underflow_o, if_b.rdata, if_b.datacount_o, if_b.empty_o},
               {1'b0, HS, 8'd16, 5'd0, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_simul_r2();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if_c.wdata   = 8'(8'hA1 + i);
      if_c.wr_en_i = 1'b1;
      tick();
    end
    if_c.wr_en_i = 1'b0;
    total_cnt++;
    if ({if_c.datacount_o, if_c.empty_o, if_c.rdata, if_c.rd_valid_o} !== {5'd3, 1'b0, 16'hA2A1, 1'b1})
      $display("FAIL simul_pre got=%h exp=%h", {if_c.datacount_o, if_c.empty_o, if_c.rdata, if_c.rd_valid_o},
               {5'd3, 1'b0, 16'hA2A1, 1'b1});
    else pass_cnt++;
    if_c.wdata   = 8'hA4;
    if_c.wr_en_i = 1'b1;
    if_c.rd_en_i = 1'b1;
    tick();
    if_c.wr_en_i = 1'b0;
    if_c.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_c.datacount_o, if_c.empty_o, if_c.rdata, if_c.rd_valid_o, if_c.wr_ack_o} !==
        {5'd2, 1'b0, 16'hA4A3, 1'b1, HS})
      $display("FAIL simul_rw got=%h exp=%h",
               {if_c.datacount_o, if_c.empty_o, if_c.rdata, if_c.rd_valid_o, if_c.wr_ack_o},
               {5'd2, 1'b0, 16'hA4A3, 1'b1, HS});
    else pass_cnt++;
    if_c.rd_en_i = 1'b1;
    tick();
    if_c.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_c.datacount_o, if_c.empty_o, if_c.rdata, if_c.rd_valid_o} !== {5'd0, 1'b1, 16'h0, 1'b0})
      $display("FAIL simul_drain got=%h exp=%h", {if_c.datacount_o, if_c.empty_o, if_c.rdata, if_c.rd_valid_o},
               {5'd0, 1'b1, 16'h0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_fwft_r2();
    do_reset();
    if_c.wdata   = 8'hAA;
    if_c.wr_en_i = 1'b1;
    tick();
    total_cnt++;
    if ({if_c.rdata, if_c.rd_valid_o, if_c.empty_o} !== {16'h0, 1'b0, 1'b1})
      $display("FAIL fwft_one got=%h exp=%h", {if_c.rdata, if_c.rd_valid_o, if_c.empty_o}, {16'h0, 1'b0, 1'b1});
    else pass_cnt++;
    if_c.wdata = 8'hBB;
    tick();
    if_c.wr_en_i = 1'b0;
    total_cnt++;
    if ({if_c.rdata, if_c.rd_valid_o, if_c.empty_o} !== {16'hBBAA, 1'b1, 1'b0})
      $display("FAIL fwft_two got=%h exp=%h", {if_c.rdata, if_c.rd_valid_o, if_c.empty_o}, {16'hBBAA, 1'b1, 1'b0});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if_c.rdata, if_c.rd_valid_o, if_c.datacount_o} !== {16'hBBAA, 1'b1, 5'd2})
      $display("FAIL fwft_hold got=%h exp=%h", {if_c.rdata, if_c.rd_valid_o, if_c.datacount_o},
               {16'hBBAA, 1'b1, 5'd2});
    else pass_cnt++;
  endtask

  task automatic test_wrap_r4();
    int          n;
    int          r;
    int          ec;
    logic [31:0] ew;
    n = 0;
    r = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if_a.wdata   = 8'(64 + n);
      if_a.wr_en_i = 1'b1;
      n++;
      tick();
    end
    total_cnt++;
    if ({if_a.datacount_o, fl_a} !== {5'd8, 6'b000000})
      $display("FAIL wrap_prefill got=%b exp=%b", {if_a.datacount_o, fl_a}, {5'd8, 6'b000000});
    else pass_cnt++;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 4; c++) begin
        if_a.wdata   = 8'(64 + n);
        if_a.wr_en_i = 1'b1;
        if_a.rd_en_i = (c == 0);
        n++;
        tick();
        ec = 5 + c;
        total_cnt++;
        if ({if_a.datacount_o, if_a.empty_o, if_a.full_o} !== {5'(ec), 1'b0, 1'b0})
          $display("FAIL wrap_count_j%0d_c%0d got=%b exp=%b", j, c,
                   {if_a.datacount_o, if_a.empty_o, if_a.full_o}, {5'(ec), 1'b0, 1'b0});
        else pass_cnt++;
        if (c == 0) begin
          ew = {8'(64 + 4*r + 3), 8'(64 + 4*r + 2), 8'(64 + 4*r + 1), 8'(64 + 4*r)};
          r++;
          total_cnt++;
          if ({if_a.rdata, if_a.rd_valid_o} !== {ew, 1'b1})
            $display("FAIL wrap_read%0d got=%h exp=%h", r - 1, {if_a.rdata, if_a.rd_valid_o}, {ew, 1'b1});
          else pass_cnt++;
        end
      end
    end
    if_a.wr_en_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if_a.rd_en_i = 1'b1;
      tick();
      ew = {8'(64 + 4*r + 3), 8'(64 + 4*r + 2), 8'(64 + 4*r + 1), 8'(64 + 4*r)};
      r++;
      total_cnt++;
      if ({if_a.rdata, if_a.rd_valid_o, if_a.datacount_o} !== {ew, 1'b1, 5'(4 - 4*d)})
        $display("FAIL wrap_drain%0d got=%h exp=%h", d, {if_a.rdata, if_a.rd_valid_o, if_a.datacount_o},
                 {ew, 1'b1, 5'(4 - 4*d)});
      else pass_cnt++;
    end
    if_a.rd_en_i = 1'b0;
    total_cnt++;
    if ({if_a.empty_o, if_a.datacount_o} !== {1'b1, 5'd0})
      $display("FAIL wrap_end got=%b exp=%b", {if_a.empty_o, if_a.datacount_o}, {1'b1, 5'd0});
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_pack_r4();
    test_reset_mid();
    test_overflow_r1();
    test_simul_r2();
    test_fwft_r2();
    test_wrap_r4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/efx_syncfifo_asym.md
EFX_SYNCFIFO_ASYM -- requirements
Module: efx_syncfifo_asym

Interface
REQ-001 SHALL have parameter DEPTH, default 512: storage depth in write words; power of 2, >=16.
REQ-002 SHALL have parameter WDATA_WIDTH, default 8: write word width.
REQ-003 SHALL have parameter RATIO, default 4, legal values 1/2/4: read word width = WDATA_WIDTH*RATIO.
REQ-004 SHALL have parameter MODE, default "STANDARD": "STANDARD" or "FWFT" (first-word-fall-through).
REQ-005 SHALL have parameter PROG_FULL_ASSERT, default DEPTH-16: prog_full_o threshold in write words.
REQ-006 SHALL have parameter PROG_EMPTY_ASSERT, default 16: prog_empty_o threshold in write words.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with ports:
  clk_i  in  1  sole clock, rising edge
  a_rst_i  in  1  synchronous active-high reset
  wr_en_i  in  1  write request
  wdata  in  WDATA_WIDTH  write data
  rd_en_i  in  1  read request
  rdata  out  WDATA_WIDTH*RATIO  read data
  full_o / almost_full_o / prog_full_o  out  1  write-side flags
  empty_o / almost_empty_o / prog_empty_o  out  1  read-side flags
  wr_ack_o / overflow_o  out  1  write handshake pulses
  rd_valid_o / underflow_o  out  1  read handshake pulses
  datacount_o  out  log2(DEPTH)+1  occupancy in write words

Function
REQ-008 SHALL accept a write when wr_en_i=1 and full_o=0; count +1.
REQ-009 SHALL accept a read when rd_en_i=1 and empty_o=0; count -RATIO.
REQ-010 SHALL pack RATIO consecutive write words per read word, earliest-written word in rdata LSBs.
REQ-011 SHALL apply simultaneous accepted read and write in one cycle: count + 1 - RATIO.
REQ-012 SHALL hold count in a register; flags are combinational from the registered count: full_o = (count==DEPTH), almost_full_o = (count>=DEPTH-1), prog_full_o = (count>=PROG_FULL_ASSERT), empty_o = (count<RATIO), almost_empty_o = (count<2*RATIO), prog_empty_o = (count<=PROG_EMPTY_ASSERT).
REQ-013 SHALL wrap write pointer modulo DEPTH and read pointer modulo DEPTH/RATIO, with no skipped entries.
REQ-014 STANDARD: rdata SHALL update one cycle after an accepted read, with rd_valid_o=1 that cycle; rdata holds otherwise.
REQ-015 FWFT: rdata SHALL present the head read word whenever empty_o=0, with rd_valid_o = !empty_o; accepted rd_en_i pops, and the next word appears the following cycle.
REQ-016 SHALL pulse wr_ack_o one cycle after each accepted write; overflow_o one cycle after wr_en_i while full_o=1.
REQ-017 SHALL pulse underflow_o one cycle after rd_en_i while empty_o=1.
REQ-018 SHALL leave contents and count unchanged on a rejected write or read.
REQ-019 SHALL never assert full_o and empty_o together.

Reset
REQ-020 On a_rst_i=1 at a clock edge, SHALL zero pointers, count and rdata, and discard contents, including mid-operation.
REQ-021 During and after reset: empty_o=1, almost_empty_o=1, prog_empty_o=1; all other outputs 0.
REQ-022 SHALL ignore wr_en_i/rd_en_i in any cycle where a_rst_i=1.

Configuration
REQ-023 With EFX_FIFO_HANDSHAKE_EN defined, SHALL generate wr_ack_o, overflow_o and underflow_o per REQ-016/017.
REQ-024 Without EFX_FIFO_HANDSHAKE_EN, those three outputs SHALL be tied 0 with no registers inferred; all other behaviour is unchanged.

Verification
REQ-025 RATIO=4, WDATA_WIDTH=8, STANDARD: write 0x11,0x22,0x33,0x44, then read -> next cycle rdata=0x44332211, rd_valid_o=1, empty_o=1.
REQ-026 DEPTH=16, RATIO=1: write 17 words -> full_o=1 after the 16th, overflow_o=1 after the 17th, datacount_o=16, 17th word absent on readback.
REQ-027 RATIO=2, count=3: read and write in the same cycle -> count=2, empty_o=0, data order preserved.
REQ-028 FWFT, RATIO=2: write 0xAA,0xBB -> rdata=0xBBAA with rd_valid_o=1, without rd_en_i.
REQ-029 Fill to count=10, assert a_rst_i one cycle -> count=0, empty_o=1, subsequent read gives underflow_o=1 (EFX_FIFO_HANDSHAKE_EN defined).
REQ-030 DEPTH=16, RATIO=4: 40 writes interleaved with 10 reads -> pointers wrap, all data read back in order, no flag glitches.
